// File: rtl/hex_marquee_if.sv
// Control, message-buffer write port and display outputs of the scrolling
// seven-segment marquee. The consumer (the marquee itself) uses the slave modport.
interface hex_marquee_if #(
  parameter int N_DIG = 5,
  parameter int DEPTH = 16
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(DEPTH + N_DIG);

  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [7:0]           wr_data;
  logic [LW-1:0]        len;
  logic                 start;
  logic                 stop;
  logic                 hold;
  logic                 dir;
  logic                 oneshot;
  logic [8*N_DIG-1:0]   hex;
  logic [FW-1:0]        frame;
  logic                 busy;
  logic                 done;

  modport master (
    output wr_en, wr_addr, wr_data, len, start, stop, hold, dir, oneshot,
    input  hex, frame, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, start, stop, hold, dir, oneshot,
    output hex, frame, busy, done
  );
endinterface

// File: rtl/hex_marquee.sv
// Scrolling marquee: steps a message held in a small segment-code buffer across
// N_DIG seven-segment digits, one frame every DIV clocks, in either direction.
module hex_marquee #(
  parameter int N_DIG = 5,
  parameter int DEPTH = 16,
  parameter int DIV   = 50000000
) (
  input  logic          clk,
  input  logic          rst,
  hex_marquee_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(DEPTH + N_DIG);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = FW + 2;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t               state_q, state_d;
  logic [FW-1:0]        frame_q, frame_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        len_q, len_d;
  logic                 dir_q, dir_d;
  logic                 once_q, once_d;
  logic                 done_q, done_d;
  logic [7:0]           msg_q [DEPTH];
  logic [8*N_DIG-1:0]   hex_p0, hex_p1;

  logic                 len_ok, tick, last;
  logic signed [IW-1:0] f_s, l_s, idx;

  assign len_ok = (bus.len != '0) && (32'(bus.len) <= DEPTH);
  assign tick   = (cnt_q == CW'(DIV - 1));
  assign last   = (frame_q == FW'(len_q) + FW'(N_DIG - 1));

  // A paused cycle with hold released counts immediately, so a hold of n cycles
  // delays the next frame by exactly n cycles.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    dir_d   = dir_q;
    once_d  = once_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.stop && bus.start && len_ok) begin
          state_d = RUN;
          len_d   = bus.len;
          dir_d   = bus.dir;
          once_d  = bus.oneshot;
          frame_d = '0;
          cnt_d   = '0;
        end
      end
      RUN, PAUSE: begin
        if (bus.stop) begin
          state_d = IDLE;
          frame_d = '0;
          cnt_d   = '0;
        end else if (bus.hold) begin
          state_d = PAUSE;
        end else begin
          state_d = RUN;
          if (!tick) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = '0;
            if (!last) begin
              frame_d = frame_q + FW'(1);
            end else begin
              frame_d = '0;
              if (once_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        frame_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      dir_q   <= 1'b0;
      once_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      once_q  <= once_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) msg_q[i] <= 8'hFF;
    end else if (bus.wr_en && (32'(bus.wr_addr) < DEPTH)) begin
      msg_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Stage p0: signed per-digit character index, out-of-range positions are blank
  assign f_s = signed'(IW'(frame_q));
  assign l_s = signed'(IW'(len_q));

  always_comb begin
    hex_p0 = {N_DIG{8'hFF}};
    idx    = '0;
    if (state_q != IDLE) begin
      for (int d = 0; d < N_DIG; d++) begin
        idx = dir_q ? (l_s - f_s + IW'(N_DIG - 1 - d)) : (f_s - IW'(1) - IW'(d));
        if (!idx[IW-1] && (idx < l_s)) hex_p0[8*d +: 8] = msg_q[idx[AW-1:0]];
      end
    end
  end

  // Stage p1: registered display
  always_ff @(posedge clk) begin
    if (rst) hex_p1 <= {N_DIG{8'hFF}};
    else     hex_p1 <= hex_p0;
  end

  assign bus.hex   = hex_p1;
  assign bus.frame = frame_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
endmodule

// File: tb/tb_hex_marquee.sv
// Bench for hex_marquee: spec vectors, hand-written corner sequences and a
// randomized run, all checked every cycle against a character-placement model.
module tb_hex_marquee;
  localparam int N_DIG = 5;
  localparam int DEPTH = 16;
  localparam int DIV   = 4;
  localparam logic [8*N_DIG-1:0] ALLFF = {N_DIG{8'hFF}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hex_marquee_if #(.N_DIG(N_DIG), .DEPTH(DEPTH)) bus ();
  hex_marquee #(.N_DIG(N_DIG), .DEPTH(DEPTH), .DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]         m_msg [DEPTH];
  bit                 m_busy, m_dir, m_once, m_done;
  int                 m_frame, m_ticks, m_len;
  logic [8*N_DIG-1:0] m_hex;

  logic [7:0] happy [5] = '{8'h89, 8'h88, 8'h8C, 8'h8C, 8'h91};

  typedef struct {
    bit                 dir;
    bit                 once;
    int                 frame;
    logic [8*N_DIG-1:0] hex;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each message character k lands on digit (f-1-k) scrolling left, or on
  // digit (LEN-f+N_DIG-1-k) scrolling right; digits nobody lands on are blank.
  function automatic logic [8*N_DIG-1:0] view(int f, bit dir, int len);
    logic [8*N_DIG-1:0] v;
    int pos;
    v = ALLFF;
    for (int k = 0; k < len; k++) begin
      pos = dir ? (len - f + N_DIG - 1 - k) : (f - 1 - k);
      if (pos >= 0 && pos < N_DIG) v[8*pos +: 8] = m_msg[k];
    end
    return v;
  endfunction

  task automatic model_step();
    logic [8*N_DIG-1:0] nh;
    nh = (m_busy && !rst) ? view(m_frame, m_dir, m_len) : ALLFF;
    if (rst) begin
      m_busy = 0; m_done = 0; m_frame = 0; m_ticks = 0;
      for (int i = 0; i < DEPTH; i++) m_msg[i] = 8'hFF;
    end else begin
      m_done = 0;
      if (bus.wr_en && int'(bus.wr_addr) < DEPTH) m_msg[bus.wr_addr] = bus.wr_data;
      if (!m_busy) begin
        if (bus.start && !bus.stop && int'(bus.len) >= 1 && int'(bus.len) <= DEPTH) begin
          m_busy = 1; m_len = int'(bus.len); m_dir = bus.dir; m_once = bus.oneshot;
          m_frame = 0; m_ticks = 0;
        end
      end else if (bus.stop) begin
        m_busy = 0; m_frame = 0; m_ticks = 0;
      end else if (!bus.hold) begin
        m_ticks++;
        if (m_ticks == DIV) begin
          m_ticks = 0;
          if (m_frame == m_len + N_DIG - 1) begin
            m_frame = 0;
            if (m_once) begin m_busy = 0; m_done = 1; end
          end else begin
            m_frame++;
          end
        end
      end
    end
    m_hex = nh;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("frame", 64'(bus.frame), 64'(m_frame));
    chk("busy",  64'(bus.busy),  64'(m_busy));
    chk("done",  64'(bus.done),  64'(m_done));
    chk("hex",   64'(bus.hex),   64'(m_hex));
  endtask

  task automatic idle_inputs();
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = 8'hFF; bus.len = '0;
    bus.start = 0; bus.stop = 0; bus.hold = 0; bus.dir = 0; bus.oneshot = 0;
  endtask

  task automatic do_reset();
    rst = 1; cycle(); rst = 0;
  endtask

  task automatic load_happy();
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1; bus.wr_addr = 4'(i); bus.wr_data = happy[i];
      cycle();
    end
    bus.wr_en = 0;
  endtask

  task automatic start_run(input bit dir, input bit once, input int len);
    bus.dir = dir; bus.oneshot = once; bus.len = 5'(len); bus.start = 1;
    cycle();
    bus.start = 0;
  endtask

  task automatic wait_frame(input int target, input int budget);
    int n = 0;
    while (int'(bus.frame) != target && n < budget) begin
      cycle();
      n++;
    end
    chk("wait_frame", 64'(bus.frame), 64'(target));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, n;
    logic [4:0]         fz;
    logic [8*N_DIG-1:0] hz;

    tbl[0] = '{1'b1, 1'b0, 1, 40'h91FFFFFFFF};
    tbl[1] = '{1'b1, 1'b0, 3, 40'h8C8C91FFFF};
    tbl[2] = '{1'b1, 1'b0, 5, 40'h89888C8C91};
    tbl[3] = '{1'b1, 1'b0, 9, 40'hFFFFFFFF89};
    tbl[4] = '{1'b0, 1'b1, 1, 40'hFFFFFFFF89};
    tbl[5] = '{1'b0, 1'b1, 3, 40'hFFFF89888C};
    tbl[6] = '{1'b0, 1'b1, 5, 40'h89888C8C91};
    tbl[7] = '{1'b0, 1'b1, 9, 40'h91FFFFFFFF};

    idle_inputs();
    rst = 1;
    m_busy = 0; m_done = 0; m_frame = 0; m_ticks = 0; m_len = 0;
    m_dir = 0; m_once = 0; m_hex = ALLFF;
    cycle();
    rst = 0;
    chk("rst_frame", 64'(bus.frame), 64'(0));
    chk("rst_busy",  64'(bus.busy),  64'(0));
    chk("rst_done",  64'(bus.done),  64'(0));
    chk("rst_hex",   64'(bus.hex),   64'(ALLFF));

    // Spec display vectors
    for (int i = 0; i < 8; i++) begin
      do_reset();
      load_happy();
      start_run(tbl[i].dir, tbl[i].once, 5);
      wait_frame(tbl[i].frame, 80);
      cycle();
      chk("tbl_hex", 64'(bus.hex), 64'(tbl[i].hex));
    end

    // Rightward loop wraps 9 -> 0 and keeps running
    do_reset(); load_happy();
    start_run(1, 0, 5);
    wait_frame(9, 80);
    wait_frame(0, 8);
    chk("wrap_busy", 64'(bus.busy), 64'(1));

    // Leftward oneshot: exactly one DONE pulse, then idle and blank
    do_reset(); load_happy();
    start_run(0, 1, 5);
    wait_frame(9, 80);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (bus.done) pulses++;
    end
    chk("done_pulses", 64'(pulses), 64'(1));
    chk("oneshot_busy", 64'(bus.busy), 64'(0));
    chk("oneshot_hex", 64'(bus.hex), 64'(ALLFF));

    // HOLD for 10 cycles at frame 3 with one tick already counted
    do_reset(); load_happy();
    start_run(1, 0, 5);
    wait_frame(3, 40);
    cycle();
    fz = bus.frame; hz = bus.hex;
    bus.hold = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("hold_frame", 64'(bus.frame), 64'(fz));
      chk("hold_hex",   64'(bus.hex),   64'(hz));
    end
    bus.hold = 0;
    n = 0;
    while (bus.frame == fz && n < 10) begin
      cycle();
      n++;
    end
    chk("hold_resume_cycles", 64'(n), 64'(DIV - 1));

    // Illegal START lengths
    do_reset(); load_happy();
    start_run(0, 0, 0);
    cycle(); cycle();
    chk("len0_busy", 64'(bus.busy), 64'(0));
    chk("len0_hex",  64'(bus.hex),  64'(ALLFF));
    start_run(1, 0, 17);
    cycle(); cycle();
    chk("len17_busy", 64'(bus.busy), 64'(0));
    chk("len17_hex",  64'(bus.hex),  64'(ALLFF));

    // STOP at frame 6 of a oneshot pass: idle, no DONE
    start_run(0, 1, 5);
    wait_frame(6, 40);
    bus.stop = 1; cycle(); bus.stop = 0;
    chk("stop_busy",  64'(bus.busy),  64'(0));
    chk("stop_frame", 64'(bus.frame), 64'(0));
    for (int i = 0; i < 40; i++) begin
      cycle();
      chk("stop_no_done", 64'(bus.done), 64'(0));
    end

    // RST at frame 4 clears everything, including the buffer
    start_run(1, 0, 5);
    wait_frame(4, 40);
    rst = 1; cycle(); rst = 0;
    chk("midrst_frame", 64'(bus.frame), 64'(0));
    chk("midrst_busy",  64'(bus.busy),  64'(0));
    chk("midrst_done",  64'(bus.done),  64'(0));
    chk("midrst_hex",   64'(bus.hex),   64'(ALLFF));
    start_run(1, 0, 5);
    for (int i = 0; i < 40; i++) begin
      cycle();
      chk("blank_after_rst", 64'(bus.hex), 64'(ALLFF));
    end

    // Live write into the visible window
    do_reset(); load_happy();
    start_run(1, 0, 5);
    wait_frame(5, 40);
    bus.wr_en = 1; bus.wr_addr = 4'd0; bus.wr_data = 8'hC0;
    cycle();
    bus.wr_en = 0;
    cycle();
    chk("live_write_hex4", 64'(bus.hex[39:32]), 64'(8'hC0));

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_addr = 4'($urandom_range(0, DEPTH - 1));
      bus.wr_data = 8'($urandom);
      bus.start   = ($urandom_range(0, 7) == 0);
      bus.stop    = ($urandom_range(0, 79) == 0);
      bus.hold    = ($urandom_range(0, 7) == 0);
      bus.dir     = 1'($urandom);
      bus.oneshot = 1'($urandom);
      bus.len     = 5'($urandom_range(0, DEPTH + 1));
      rst         = ($urandom_range(0, 599) == 0);
      cycle();
    end
    rst = 0;
    idle_inputs();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
